// File: rtl/muxn_pkg.sv
// muxn_pkg: shared types and helpers for the muxn_rr round-robin stream multiplexer.
package muxn_pkg;

  // Arbitration FSM: IDLE picks a channel, LOCK streams it until its last beat.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Width of a channel index; a single-channel mux still carries a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muxn_arb.sv
// muxn_arb: combinational wrap-around priority finder for muxn_rr.
// Searches req upward starting at ptr, wrapping N-1 to 0.
// With MUXN_RR_FIXED_PRIO_EN defined, ptr is ignored and the lowest-index request wins.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx
);

`ifdef MUXN_RR_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: the first requesting channel counting up from zero wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[k]) begin
        any = 1'b1;
        idx = SW'(k);
      end
    end
  end

`else

  logic [SW-1:0] cand;

  // Round robin: walk the channels starting at ptr and take the first request seen.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = SW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

`endif

endmodule

// File: rtl/muxn_rr.sv
// muxn_rr: N-channel, W-bit valid/ready stream mux with round-robin arbitration,
// packet locking and a registered output stage.
// Optional build macro MUXN_RR_FIXED_PRIO_EN switches to fixed lowest-index priority
// and removes the round-robin pointer.
module muxn_rr
  import muxn_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  state_e        state_q, state_d;
  logic [SW-1:0] g_q, g_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic [SW-1:0] arb_ptr;
  logic          arb_any;
  logic [SW-1:0] arb_idx;

  logic [W-1:0]  sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          grant_ready;
  logic          accept;

`ifdef MUXN_RR_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [SW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  muxn_arb #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req (in_valid),
    .ptr (arb_ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  // Pick out the granted channel's data, valid and last.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (g_q == SW'(k)) begin
        sel_data  = in_data[k*W +: W];
        sel_valid = in_valid[k];
        sel_last  = in_last[k];
      end
    end
  end

  // The granted channel is ready whenever the output register is empty or draining.
  always_comb begin
    grant_ready = !out_valid_q || out_ready;
    in_ready    = '0;
    if (state_q == LOCK) begin
      for (int k = 0; k < N; k++) begin
        if (g_q == SW'(k)) begin
          in_ready[k] = grant_ready;
        end
      end
    end
  end

  assign accept = (state_q == LOCK) && sel_valid && grant_ready;

  // Next-state logic: arbitration in IDLE, beat transfer and packet end in LOCK.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
`ifndef MUXN_RR_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          g_d     = arb_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          out_data_d  = sel_data;
          out_last_d  = sel_last;
          out_sel_d   = g_q;
          out_valid_d = 1'b1;
          if (sel_last) begin
            state_d = IDLE;
`ifndef MUXN_RR_FIXED_PRIO_EN
            ptr_d   = (g_q == SW'(N - 1)) ? '0 : g_q + SW'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
`ifndef MUXN_RR_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
`ifndef MUXN_RR_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: self-checking bench for muxn_rr (N=4, W=8).
// A cycle-level reference model built from integer owner/pointer bookkeeping predicts
// every output, and a per-channel scoreboard checks that each delivered beat matches
// the producer's stream in order, that packets are never interleaved and nothing is lost.
module tb_muxn_rr;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SW    = 2;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  muxn_rr #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Producer streams: {last, data} per beat, head = next beat to offer, tail = next free.
  logic [W:0] src_mem [N][DEPTH];
  int         src_head [N];
  int         src_tail [N];
  int         exp_head [N];
  bit         consumed [N];

  int ready_mode;   // 0: always ready, 1: random, 2: stalled
  bit eager;
  bit gen_en;
  int cyc;
  int cur_pkt_ch;

  int         sel_log [$];
  logic [W:0] data_log [$];
  int         time_log [$];

  // Reference model: owning channel (-1 when arbitrating), rotation start, output beat.
  int         m_owner;
  int         m_rr;
  bit         m_ov;
  logic [W-1:0] m_data;
  bit         m_last;
  int         m_sel;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic pushPacket(input int ch, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      src_mem[ch][src_tail[ch] % DEPTH] = {(b == len - 1) ? 1'b1 : 1'b0, W'(int'(base) + b)};
      src_tail[ch]++;
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_rr    = 0;
    m_ov    = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_sel   = 0;
  endtask

  function automatic bit allDone();
    for (int k = 0; k < N; k++) begin
      if (exp_head[k] != src_tail[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive producers and the consumer for the coming clock edge.
  task automatic applyStimulus();
    int ch;
    int len;
    if (gen_en && $urandom_range(0, 5) == 0) begin
      ch  = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      if (src_tail[ch] + len - exp_head[ch] <= DEPTH) pushPacket(ch, len, W'($urandom));
    end
    for (int k = 0; k < N; k++) begin
      if (consumed[k]) begin
        in_valid[k] = 1'b0;
        consumed[k] = 1'b0;
      end
      if (!in_valid[k]) begin
        if (src_tail[k] > src_head[k] && (eager || $urandom_range(0, 3) != 0)) begin
          in_valid[k] = 1'b1;
          {in_last[k], in_data[k*W +: W]} = src_mem[k][src_head[k] % DEPTH];
        end else begin
          in_data[k*W +: W] = W'($urandom);
          in_last[k]        = 1'($urandom);
        end
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  // Advance the reference model across one clock edge using the current inputs.
  task automatic modelStep();
    bit acc;
    int ch;
    int pick;
    acc = 1'b0;
    if (m_owner >= 0) acc = in_valid[m_owner] && (!m_ov || out_ready);
    if (acc) begin
      m_ov   = 1'b1;
      m_data = in_data[m_owner*W +: W];
      m_last = in_last[m_owner];
      m_sel  = m_owner;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      pick = -1;
      for (int i = 0; i < N; i++) begin
`ifdef MUXN_RR_FIXED_PRIO_EN
        ch = i;
`else
        ch = (m_rr + i) % N;
`endif
        if (pick < 0 && in_valid[ch]) pick = ch;
      end
      m_owner = pick;
    end else if (acc && in_last[m_owner]) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  // One full cycle: drive, compare against model and scoreboard, then clock.
  task automatic runCycle();
    logic [N-1:0] exp_ready;
    int k;
    applyStimulus();
    #1;
    for (int i = 0; i < N; i++) exp_ready[i] = (i == m_owner) && (!m_ov || out_ready);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
    checkOutput("out_data", 32'(out_data), 32'(m_data));
    checkOutput("out_last", 32'(out_last), 32'(m_last));
    checkOutput("out_sel", 32'(out_sel), 32'(m_sel));
    if (out_valid && out_ready) begin
      k = int'(out_sel);
      checkOutput("sb_pending", 32'(exp_head[k] < src_head[k]), 32'd1);
      if (exp_head[k] < src_head[k]) begin
        checkOutput("sb_beat", 32'({out_last, out_data}), 32'(src_mem[k][exp_head[k] % DEPTH]));
        exp_head[k]++;
      end
      if (cur_pkt_ch >= 0) checkOutput("pkt_lock", 32'(out_sel), 32'(cur_pkt_ch));
      cur_pkt_ch = out_last ? -1 : k;
      sel_log.push_back(k);
      data_log.push_back({out_last, out_data});
      time_log.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        src_head[i]++;
        consumed[i] = 1'b1;
      end
    end
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset with random inputs and require every output to read zero.
  task automatic doReset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst       = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_head[k] = 0;
      src_tail[k] = 0;
      exp_head[k] = 0;
      consumed[k] = 1'b0;
    end
    cur_pkt_ch = -1;
    modelReset();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!allDone() && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput(tag, 32'(allDone()), 32'd1);
  endtask

  task automatic clearLogs();
    sel_log.delete();
    data_log.delete();
    time_log.delete();
  endtask

  // Directed scenarios followed by a long randomized run with a mid-run reset.
  initial begin
    int exp_rr [6];
    int n;
    logic [W-1:0]  held_data;
    logic [SW-1:0] held_sel;

    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    ready_mode = 0; eager = 1'b1; gen_en = 1'b0; cyc = 0; cur_pkt_ch = -1;
    modelReset();

    $display("[TB] reset and idle");
    doReset(2);
    runCycle();
    runCycle();

    $display("[TB] single beat latency");
    pushPacket(2, 1, 8'hA5);
    runCycle();
    checkOutput("lat_ready_t1", 32'(in_ready), 32'h4);
    runCycle();
    checkOutput("lat_valid_t2", 32'(out_valid), 32'd1);
    checkOutput("lat_data_t2", 32'(out_data), 32'hA5);
    checkOutput("lat_sel_t2", 32'(out_sel), 32'd2);
    checkOutput("lat_last_t2", 32'(out_last), 32'd1);
    checkOutput("lat_ready_off", 32'(in_ready), 32'd0);
    drain("lat_drain", 10);

    $display("[TB] arbitration order");
    doReset(2);
    clearLogs();
    for (int ch = 0; ch < N; ch++) begin
      pushPacket(ch, 1, W'(16 * ch));
      pushPacket(ch, 1, W'(16 * ch + 1));
    end
`ifdef MUXN_RR_FIXED_PRIO_EN
    exp_rr = '{0, 0, 1, 1, 2, 2};
`else
    exp_rr = '{0, 1, 2, 3, 0, 1};
`endif
    n = 0;
    while (sel_log.size() < 6 && n < 60) begin
      runCycle();
      n++;
    end
    checkOutput("rr_count", 32'(sel_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < sel_log.size()) checkOutput($sformatf("rr_sel%0d", i), 32'(sel_log[i]), 32'(exp_rr[i]));
      if (i + 1 < time_log.size()) checkOutput($sformatf("rr_gap%0d", i), 32'(time_log[i+1] - time_log[i]), 32'd2);
    end
    drain("rr_drain", 60);

    $display("[TB] packet lock");
    doReset(2);
    clearLogs();
    pushPacket(1, 3, 8'h11);
    runCycle();
    pushPacket(0, 1, 8'h01);
    drain("lock_drain", 40);
    checkOutput("lock_count", 32'(data_log.size()), 32'd4);
    if (data_log.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("lock_data%0d", i), 32'(data_log[i]), 32'({(i == 2) ? 1'b1 : 1'b0, W'(8'h11 + i)}));
        checkOutput($sformatf("lock_sel%0d", i), 32'(sel_log[i]), 32'd1);
      end
      checkOutput("lock_back2back_a", 32'(time_log[1] - time_log[0]), 32'd1);
      checkOutput("lock_back2back_b", 32'(time_log[2] - time_log[1]), 32'd1);
      checkOutput("lock_then_ch0", 32'(sel_log[3]), 32'd0);
    end

    $display("[TB] backpressure");
    doReset(2);
    clearLogs();
    pushPacket(2, 3, 8'hC0);
    n = 0;
    while (!out_valid && n < 10) begin
      runCycle();
      n++;
    end
    checkOutput("bp_started", 32'(out_valid), 32'd1);
    held_data  = out_data;
    held_sel   = out_sel;
    ready_mode = 2;
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput("bp_data_hold", 32'(out_data), 32'(held_data));
      checkOutput("bp_sel_hold", 32'(out_sel), 32'd2);
      checkOutput("bp_sel_same", 32'(out_sel), 32'(held_sel));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    ready_mode = 0;
    drain("bp_drain", 20);
    checkOutput("bp_count", 32'(data_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < data_log.size())
        checkOutput($sformatf("bp_beat%0d", i), 32'(data_log[i]), 32'({(i == 2) ? 1'b1 : 1'b0, W'(8'hC0 + i)}));
    end

    $display("[TB] randomized traffic");
    doReset(2);
    ready_mode = 1;
    eager      = 1'b0;
    gen_en     = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      runCycle();
      if (i == 600) doReset(2);
    end
    gen_en     = 1'b0;
    eager      = 1'b1;
    ready_mode = 0;
    drain("rand_drain", 3000);
    for (int k = 0; k < N; k++) checkOutput($sformatf("no_loss_ch%0d", k), 32'(exp_head[k]), 32'(src_tail[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
